// File: rtl/dac_intf_mc.sv
// dac_intf_mc -- multi-channel TX DAC interface.
//
// Buffers IQ samples from the TX datapath in a synchronous FIFO, waits for a
// prefill threshold (or a complete packet) before streaming, and steers each
// popped sample onto the DAC channel slices selected by a latched enable mask.
// With the internal path deselected the DMA stream passes straight through.
//
// Ports
//   dac_clk_i          sole clock
//   dac_rst_i          synchronous active-high reset
//   dac_data_o         DAC bus, NUM_CH slices of SW bits
//   dac_valid_o        DAC valid (constant 1 on the internal path)
//   dac_ready_i        unpacker sample strobe
//   dma_data_i         DMA samples
//   dma_valid_i        DMA valid
//   dma_ready_o        DMA ready
//   src_sel_i          0 = DMA passthrough, 1 = internal path
//   ch_en_i            channel enable mask, latched at packet start
//   data_in_i          sample from the TX datapath
//   data_in_last_i     last sample of a packet
//   data_in_valid_i    write request
//   data_in_ready_o    FIFO can accept a write
//   fifo_level_o       current FIFO occupancy
//   underrun_o         one-cycle pulse per underrun cycle
//   underrun_cnt_o     saturating underrun count
//   busy_o             state machine not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no packet in progress; src_sel may be reloaded when empty
// PREFILL | packet started, waiting for START_LEVEL entries or a last
// STREAM  | popping one entry per dac_ready strobe, zeros on underrun

module dac_intf_mc #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int NUM_CH        = 2,
    parameter int FIFO_DEPTH    = 32,
    parameter int START_LEVEL   = 8
) (
    input  logic                                   dac_clk_i,
    input  logic                                   dac_rst_i,
    output logic [NUM_CH*2*IQ_DATA_WIDTH-1:0]      dac_data_o,
    output logic                                   dac_valid_o,
    input  logic                                   dac_ready_i,
    input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0]      dma_data_i,
    input  logic                                   dma_valid_i,
    output logic                                   dma_ready_o,
    input  logic                                   src_sel_i,
    input  logic [NUM_CH-1:0]                      ch_en_i,
    input  logic [2*IQ_DATA_WIDTH-1:0]             data_in_i,
    input  logic                                   data_in_last_i,
    input  logic                                   data_in_valid_i,
    output logic                                   data_in_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]            fifo_level_o,
    output logic                                   underrun_o,
    output logic [15:0]                            underrun_cnt_o,
    output logic                                   busy_o
);

    localparam int SW = 2 * IQ_DATA_WIDTH;
    localparam int DW = NUM_CH * SW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [AW:0] START_L = LW'(START_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SW:0]        mem_q [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]        last_cnt_q, last_cnt_d;
    logic [AW:0]        level;
    logic               src_eff_q;
    logic [NUM_CH-1:0]  ch_lat_q, ch_lat_d;
    logic [DW-1:0]      out_q, out_d;
    logic               underrun_q, underrun_d;
    logic [15:0]        ur_cnt_q, ur_cnt_d;
    logic [DW-1:0]      steer;
    logic [SW:0]        rd_entry;
    logic               empty, full, wr_en, pop;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign level    = wr_ptr_q - rd_ptr_q;
    assign empty    = (level == '0);
    assign full     = (level == DEPTH_L);
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    assign data_in_ready_o = src_eff_q & ~full;
    assign wr_en           = data_in_valid_i & data_in_ready_o;

    always_comb begin
        steer = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_lat_q[c]) steer[c*SW +: SW] = rd_entry[SW-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_lat_d   = ch_lat_q;
        out_d      = out_q;
        underrun_d = 1'b0;
        ur_cnt_d   = ur_cnt_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    state_d  = ST_PREFILL;
                    ch_lat_d = ch_en_i;
                end
                if (dac_ready_i) out_d = '0;
            end
            ST_PREFILL: begin
                if (level >= START_L || last_cnt_q != '0) state_d = ST_STREAM;
                if (dac_ready_i) out_d = '0;
            end
            ST_STREAM: begin
                if (dac_ready_i) begin
                    if (!empty) begin
                        pop   = 1'b1;
                        out_d = steer;
                        if (rd_entry[SW]) state_d = ST_IDLE;
                    end else begin
                        out_d      = '0;
                        underrun_d = 1'b1;
                        if (ur_cnt_q != 16'hFFFF) ur_cnt_d = ur_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_cnt_d = last_cnt_q;
        if (wr_en && data_in_last_i) last_cnt_d = last_cnt_d + 1'b1;
        if (pop && rd_entry[SW])     last_cnt_d = last_cnt_d - 1'b1;
    end

    always_ff @(posedge dac_clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {data_in_last_i, data_in_i};
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_cnt_q <= '0;
            src_eff_q  <= 1'b0;
            ch_lat_q   <= '0;
            out_q      <= '0;
            underrun_q <= 1'b0;
            ur_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_cnt_q <= last_cnt_d;
            ch_lat_q   <= ch_lat_d;
            out_q      <= out_d;
            underrun_q <= underrun_d;
            ur_cnt_q   <= ur_cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            // Source switches only between packets, never mid-stream.
            if (state_q == ST_IDLE && empty) src_eff_q <= src_sel_i;
        end
    end

    assign dac_data_o     = src_eff_q ? out_q : dma_data_i;
    assign dac_valid_o    = src_eff_q ? 1'b1  : dma_valid_i;
    assign dma_ready_o    = src_eff_q ? 1'b0  : dac_ready_i;
    assign fifo_level_o   = level;
    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = ur_cnt_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule
